// File: rtl/frodo_row_mac_ctrl.sv
// frodo_row_mac_ctrl: sequences one row inner product (A-row x S-column + e)
// through an external multi-cycle multiply-add unit, one element at a time.
// Per element: FETCH (address out) -> ISSUE (capture operands) -> WAIT (until
// the unit reports done). Accumulation wraps mod 2^16.
// Optional feature: define FRODO_ROW_MAC_RANGE_CHECK_EN to flag S values
// outside -16..15 on the sticky err output.
`timescale 1ns/1ps
module frodo_row_mac_ctrl #(
    parameter int N_LEN  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [15:0]       acc_init,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_rdata,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [7:0]        s_rdata,
    output logic              mac_en,
    output logic [15:0]       mac_a,
    output logic [7:0]        mac_b,
    output logic [15:0]       mac_c,
    input  logic              mac_done,
    input  logic [15:0]       mac_result,
    output logic              busy,
    output logic              done,
    output logic [15:0]       row_result,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_LEN - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [15:0]       r_acc;
    logic              r_mac_en;
    logic [15:0]       r_mac_a;
    logic [7:0]        r_mac_b;
    logic [15:0]       r_mac_c;
    logic [15:0]       r_row_result;
    logic              w_accept;
    logic              w_elem_done;
    logic              w_last;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_elem_done = (r_state == WAIT) && mac_done;
    assign w_last      = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; mac_done outside WAIT has no effect
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (mac_done) w_next = w_last ? FIN : FETCH;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == FIN);
    end

    // Element index and accumulator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_acc <= acc_init;
        end else if (w_elem_done) begin
            r_acc <= mac_result;
            if (!w_last) r_idx <= r_idx + 1'b1;
        end
    end

    // Operand capture in ISSUE; issue strobe covers exactly the first WAIT cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mac_en <= 1'b0;
            r_mac_a  <= '0;
            r_mac_b  <= '0;
            r_mac_c  <= '0;
        end else begin
            r_mac_en <= (r_state == ISSUE);
            if (r_state == ISSUE) begin
                r_mac_a <= a_rdata;
                r_mac_b <= s_rdata;
                r_mac_c <= r_acc;
            end
        end
    end

    // Final sum is latched on entry to FIN so it is already valid while done
    // is high; it then holds until the next row completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                     r_row_result <= '0;
        else if (w_elem_done && w_last) r_row_result <= mac_result;
    end

`ifdef FRODO_ROW_MAC_RANGE_CHECK_EN
    logic r_err;
    logic w_s_oob;

    // S is legal only when its top four bits are pure sign extension
    assign w_s_oob = (s_rdata[7:4] != 4'h0) && (s_rdata[7:4] != 4'hF);

    // Sticky range flag, cleared by an accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                               r_err <= 1'b0;
        else if (w_accept)                       r_err <= 1'b0;
        else if ((r_state == ISSUE) && w_s_oob)  r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign a_addr     = r_idx;
    assign s_addr     = r_idx;
    assign mac_en     = r_mac_en;
    assign mac_a      = r_mac_a;
    assign mac_b      = r_mac_b;
    assign mac_c      = r_mac_c;
    assign row_result = r_row_result;

endmodule

// File: tb/tb_frodo_row_mac_ctrl.sv
// Bench for frodo_row_mac_ctrl with N_LEN=4: synchronous A/S memories, a
// 2-cycle multiply-add unit model, and a scoreboard of expected row results.
`timescale 1ns/1ps
module tb_frodo_row_mac_ctrl;

    localparam int N      = 4;
    localparam int ADDR_W = 10;
    localparam int LAT    = 5 * N;

    typedef struct {
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [15:0]       acc_init;
    logic [ADDR_W-1:0] a_addr, s_addr;
    logic [15:0]       a_rdata;
    logic [7:0]        s_rdata;
    logic              mac_en, mac_done;
    logic [15:0]       mac_a, mac_c, mac_result;
    logic [7:0]        mac_b;
    logic              busy, done, err;
    logic [15:0]       row_result;

    logic [15:0] a_mem [0:(1<<ADDR_W)-1];
    logic [7:0]  s_mem [0:(1<<ADDR_W)-1];
    logic        d1, d2, inj;
    logic [15:0] bext;
    int          cyc, start_cyc, en_cnt, done_cnt;
    int          n_vec, n_bad;
    exp_t        exp_q[$];

    frodo_row_mac_ctrl #(.N_LEN(N), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .acc_init(acc_init),
        .a_addr(a_addr), .a_rdata(a_rdata), .s_addr(s_addr), .s_rdata(s_rdata),
        .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_done(mac_done), .mac_result(mac_result),
        .busy(busy), .done(done), .row_result(row_result), .err(err)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency
    always @(posedge clk) begin
        a_rdata <= a_mem[a_addr];
        s_rdata <= s_mem[s_addr];
    end

    // Two-cycle multiply-add unit; inj forces a stray done with a poison value
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin d1 <= 1'b0; d2 <= 1'b0; end
        else       begin d1 <= mac_en; d2 <= d1; end
    end
    assign bext       = {{8{mac_b[7]}}, mac_b};
    assign mac_done   = d2 | inj;
    assign mac_result = inj ? 16'h1234 : 16'(mac_a * bext + mac_c);

    // Cycle counter, accepted-start timestamp, issue-strobe counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start && !busy && rstn) begin
            start_cyc <= cyc + 1;
            en_cnt    <= 0;
        end else if (mac_en) begin
            en_cnt <= en_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: each done pops one expected row
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("row_result", {16'h0, row_result}, {16'h0, e.res});
                chk("latency", cyc - start_cyc, LAT);
                chk("mac_en_cnt", en_cnt, N);
                chk("err_at_done", {31'h0, err}, {31'h0, e.err});
            end
        end
    end

    function automatic exp_t model(input logic [15:0] init);
        exp_t e;
        e.res = init;
        e.err = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.res = 16'(e.res + a_mem[i] * {{8{s_mem[i][7]}}, s_mem[i]});
`ifdef FRODO_ROW_MAC_RANGE_CHECK_EN
            if (s_mem[i][7:4] != 4'h0 && s_mem[i][7:4] != 4'hF) e.err = 1'b1;
`endif
        end
        return e;
    endfunction

    task automatic load(input logic [63:0] a, input logic [31:0] s);
        for (int i = 0; i < N; i++) begin
            a_mem[i] = a[16*i +: 16];
            s_mem[i] = s[8*i +: 8];
        end
    endtask

    // One row: optional repeated starts at busy cycles 3 and 10, optional
    // stray mac_done during FETCH
    task automatic run_row(input logic [15:0] init, input bit dup, input bit inj_fetch);
        int k;
        @(negedge clk);
        start = 1'b1; acc_init = init;
        exp_q.push_back(model(init));
        @(negedge clk);
        start = 1'b0; k = 1;
        if (inj_fetch) begin
            inj = 1'b1;
            @(negedge clk);
            inj = 1'b0; k++;
        end
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(negedge clk);
            k++;
            start = dup && (k == 3 || k == 10);
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            chk("row_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    localparam logic [63:0] A030 = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [31:0] S030 = {8'hF0, 8'h02, 8'hFF, 8'h01};

    initial begin
        int seen, dc;
        n_vec = 0; n_bad = 0; cyc = 0; start_cyc = 0; en_cnt = 0; done_cnt = 0;
        rstn = 1'b0; start = 1'b0; acc_init = '0; inj = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin a_mem[i] = '0; s_mem[i] = '0; end
        #12;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_mac_en", {31'h0, mac_en}, 32'd0);
        chk("rst_row_result", {16'h0, row_result}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_addr", {22'h0, a_addr}, 32'd0);
        @(negedge clk); rstn = 1'b1;

        // Basic row and wrap-around row
        load(A030, S030);
        run_row(16'd5, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("row_result_hold", {16'h0, row_result}, 32'h0000FFCA);
        // Stray mac_done in IDLE
        inj = 1'b1; @(negedge clk); inj = 1'b0; @(negedge clk);
        chk("idle_inj_busy", {31'h0, busy}, 32'd0);
        chk("idle_inj_result", {16'h0, row_result}, 32'h0000FFCA);

        load({4{16'hFFFF}}, {4{8'h0F}});
        run_row(16'd0, 1'b0, 1'b0);
        chk("wrap_result", {16'h0, row_result}, 32'h0000FFC4);

        // Starts while busy are ignored
        load(A030, S030);
        run_row(16'd5, 1'b1, 1'b0);

        // Reset during WAIT of element 2
        @(negedge clk);
        start = 1'b1; acc_init = 16'd5;
        @(negedge clk);
        start = 1'b0; seen = 0;
        for (int n = 0; n < 100 && seen < 3; n++) begin
            if (mac_en) seen++;
            if (seen < 3) @(negedge clk);
        end
        chk("reach_elem2", seen, 3);
        dc = done_cnt;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'd0);
        chk("mid_rst_mac_en", {31'h0, mac_en}, 32'd0);
        chk("mid_rst_mac_a", {16'h0, mac_a}, 32'd0);
        chk("mid_rst_mac_b", {24'h0, mac_b}, 32'd0);
        chk("mid_rst_mac_c", {16'h0, mac_c}, 32'd0);
        chk("mid_rst_row_result", {16'h0, row_result}, 32'd0);
        chk("mid_rst_addr", {22'h0, s_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        run_row(16'd5, 1'b0, 1'b0);
        chk("restart_result", {16'h0, row_result}, 32'h0000FFCA);

        // Stray mac_done during FETCH
        run_row(16'd5, 1'b0, 1'b1);

        // Out-of-range S value
        load(A030, {8'hF0, 8'h02, 8'h20, 8'h01});
        run_row(16'd5, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
`ifdef FRODO_ROW_MAC_RANGE_CHECK_EN
        chk("err_sticky", {31'h0, err}, 32'd1);
`else
        chk("err_sticky", {31'h0, err}, 32'd0);
`endif
        load(A030, S030);
        run_row(16'd5, 1'b0, 1'b0);
        chk("err_cleared", {31'h0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frodo_row_mac_ctrl.md
FRODO_ROW_MAC_CTRL -- requirements
Module: frodo_row_mac_ctrl

Interface
REQ-001 SHALL have parameter N_LEN, default 640, meaning inner-product length (elements per row), legal range 1..1023.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning width of element index / memory address.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to compute one row.
REQ-006 SHALL have port acc_init  in  16  error term e, sampled with start.
REQ-007 SHALL have port a_addr  out  ADDR_W  read address, A-row memory; port a_rdata  in  16  its data.
REQ-008 SHALL have port s_addr  out  ADDR_W  read address, S-column memory; port s_rdata  in  8  its data, signed, legal -16..15.
REQ-009 SHALL have port mac_en  out  1  one-cycle issue strobe to the multiply-add unit.
REQ-010 SHALL have ports mac_a  out  16, mac_b  out  8, mac_c  out  16: multiplier, signed multiplicand, addend.
REQ-011 SHALL have ports mac_done  in  1 and mac_result  in  16: completion pulse and a*b+c mod 2^16.
REQ-012 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), row_result  out  16, err  out  1.

Function
REQ-013 SHALL implement states IDLE, FETCH, ISSUE, WAIT, FIN.
REQ-014 IDLE: on start=1, load acc<=acc_init, idx<=0, err<=0, go FETCH; start while not IDLE SHALL be ignored.
REQ-015 a_addr and s_addr SHALL equal registered idx; memories have 1-cycle synchronous read latency.
REQ-016 FETCH SHALL last one cycle, then ISSUE.
REQ-017 ISSUE SHALL register mac_a<=a_rdata, mac_b<=s_rdata, mac_c<=acc, set mac_en<=1, go WAIT.
REQ-018 mac_en SHALL be high exactly the first WAIT cycle; mac_a/b/c SHALL hold stable throughout WAIT.
REQ-019 WAIT on mac_done=1: acc<=mac_result; if idx==N_LEN-1 go FIN, else idx<=idx+1, go FETCH.
REQ-020 mac_done in any state other than WAIT SHALL be ignored; WAIT has no timeout.
REQ-021 FIN: done=1 for one cycle, row_result<=acc, go IDLE.
REQ-022 With a 2-cycle multiply-add unit each element SHALL take 5 cycles; start sampled at edge E gives done high in the cycle after edge E+5*N_LEN.
REQ-023 busy SHALL be 1 in all states except IDLE.
REQ-024 Accumulation SHALL wrap mod 2^16; no saturation, no overflow flag.
REQ-025 row_result SHALL hold its value until the next FIN.

Reset
REQ-026 rstn=0 SHALL force state IDLE, idx=0, acc=0, mac_en=0, mac_a=0, mac_b=0, mac_c=0, busy=0, done=0, row_result=0, err=0, immediately and regardless of clk.
REQ-027 Reset mid-operation SHALL abandon the row without a done pulse; the next start SHALL restart from idx 0.

Configuration
REQ-028 Macro FRODO_ROW_MAC_RANGE_CHECK_EN defined: in ISSUE, if s_rdata[7:4] is not all-equal (value outside -16..15), err SHALL set sticky until the next accepted start; computation continues unchanged.
REQ-029 Macro undefined: err SHALL be constant 0 and the check logic SHALL be absent.

Verification
REQ-030 N_LEN=4, a={1,2,3,4}, s={1,-1,2,-16}, acc_init=5 -> row_result=0xFFCA, done pulse 20 cycles after start, exactly 4 mac_en pulses.
REQ-031 N_LEN=4, a=all 0xFFFF, s=all 15, acc_init=0 -> row_result=0xFFC4 (wrap-around).
REQ-032 start asserted again at the 3rd and 10th cycle of busy -> ignored; result and timing identical to REQ-030.
REQ-033 rstn pulsed low during WAIT of element 2 -> all outputs zero at once, no done; subsequent start with REQ-030 data -> 0xFFCA.
REQ-034 s[1]=0x20 with FRODO_ROW_MAC_RANGE_CHECK_EN defined -> err=1 from element 1 to next start; undefined -> err=0.
REQ-035 mac_done pulsed in IDLE and FETCH -> no acc change, no state change.
